spi_bus_arbiter: RTL
====================

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters sharing the SPI master.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, idle-grant watchdog limit in clock cycles.
REQ-003 clock  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-requester bus request, level, held for the whole tenure.
REQ-006 start_in  input  NUM_REQ  per-requester one-cycle transfer start strobe.
REQ-007 grant  output  NUM_REQ  one-hot registered grant, all-zero when bus free.
REQ-008 done_out  output  NUM_REQ  one-cycle transfer-complete strobe to the granted requester.
REQ-009 spi_start  output  1  one-cycle start strobe to the shared SPI master.
REQ-010 spi_done  input  1  one-cycle completion strobe from the SPI master.
REQ-011 spi_ss  input  1  active-low slave select driven by the SPI master.
REQ-012 ss_out  output  NUM_REQ  active-low per-device slave selects.
REQ-013 timeout  output  1  one-cycle watchdog revoke strobe.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT, BUSY, RELEASE.
REQ-015 IDLE: any req bit set -> GRANT next cycle, grant registered (1-cycle request-to-grant latency).
REQ-016 Selection SHALL be round-robin: search starts at index ptr, wraps NUM_REQ-1 -> 0, first set req wins.
REQ-017 GRANT: start_in[g] of the granted index g SHALL drive spi_start combinationally in the same cycle and move the FSM to BUSY.
REQ-018 start_in from non-granted requesters, and any start_in while in BUSY, RELEASE or IDLE, SHALL be ignored.
REQ-019 BUSY: spi_done -> done_out[g] high exactly one cycle later (registered), FSM back to GRANT.
REQ-020 Burst: while req[g] stays high the requester keeps the grant and may issue further starts.
REQ-021 GRANT with req[g] low -> RELEASE; req[g] dropped during BUSY SHALL NOT abort, release follows completion.
REQ-022 RELEASE: grant all-zero for exactly one cycle, ptr <= (g+1) mod NUM_REQ, then IDLE.
REQ-023 ss_out[i] = spi_ss when grant[i]=1, else 1; ss_out SHALL be all-ones when grant is zero.
REQ-024 Simultaneous req in IDLE: only the round-robin winner is granted; the others wait with no lost requests.
REQ-025 spi_done outside BUSY SHALL be ignored and produce no done_out.

Reset
REQ-026 While reset is high at a clock edge: state=IDLE, grant=0, done_out=0, timeout=0, ptr=0, watchdog count=0.
REQ-027 spi_start SHALL be 0 and ss_out all-ones during reset; reset mid-BUSY abandons the transfer with no done_out.

Configuration
REQ-028 With macro SPI_ARB_TIMEOUT_EN defined, a counter SHALL clear on each GRANT entry, spi_start and spi_done, and increment in GRANT/BUSY otherwise.
REQ-029 With SPI_ARB_TIMEOUT_EN, count reaching TIMEOUT_CYCLES-1 SHALL force RELEASE, pulse timeout one cycle, and suppress done_out for the abandoned transfer.
REQ-030 Without SPI_ARB_TIMEOUT_EN, no counter SHALL be built, timeout SHALL be tied 0, and grant is held indefinitely.

Verification
REQ-031 req=3'b001, start_in[0] pulse, spi_done 40 cycles later -> grant=001 one cycle after req, spi_start same cycle as start, done_out=001 one cycle after spi_done.
REQ-032 req=3'b111 held, each requester does one transfer then drops req -> grants in order 001,010,100, each separated by one all-zero RELEASE cycle.
REQ-033 Requester 1 granted, start_in[2] pulsed -> no spi_start; spi_ss low -> ss_out=3'b101.
REQ-034 req[0] dropped mid-BUSY -> transfer completes, done_out[0] pulses, then grant=000 for one cycle.
REQ-035 Macro defined, TIMEOUT_CYCLES=16, grant held with no start -> timeout pulse 15 cycles after grant, grant=000 next; macro undefined -> grant held, timeout stays 0.
REQ-036 reset asserted during BUSY -> next cycle grant=000, done_out=000, ss_out=111; later spi_done produces no done_out.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master; grant 1 cycle after req, done_out 1 cycle after spi_done.
// Optional idle-grant watchdog (macro SPI_ARB_TIMEOUT_EN) revokes stalled tenures; no backpressure.
module spi_bus_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] start_in,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done_out,
    output logic               spi_start,
    input  logic               spi_done,
    input  logic               spi_ss,
    output logic [NUM_REQ-1:0] ss_out,
    output logic               timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;

    state_t             st_q, st_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      nxt_ptr, base, win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_vld;
    logic               wd_hit;

    assign nxt_ptr = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);

    // RELEASE re-arbitrates from the advanced pointer so consecutive tenures
    // are separated by exactly one all-zero grant cycle.
    assign base = (st_q == RELEASE) ? nxt_ptr : ptr_q;

    always_comb begin : arb_search
        int j;
        win_vld = 1'b0;
        win_idx = base;
        win_oh  = '0;
        j       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(base) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[IW'(j)]) begin
                win_vld = 1'b1;
                win_idx = IW'(j);
            end
        end
        win_oh[win_idx] = 1'b1;
    end

    assign spi_start = (st_q == GRANT) && req[gidx_q] && start_in[gidx_q] && !wd_hit && !reset;

    always_comb begin
        st_d    = st_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        done_d  = '0;
        case (st_q)
            IDLE: begin
                if (win_vld) begin
                    st_d    = GRANT;
                    grant_d = win_oh;
                    gidx_d  = win_idx;
                end
            end
            GRANT: begin
                if (wd_hit || !req[gidx_q]) begin
                    st_d    = RELEASE;
                    grant_d = '0;
                end else if (start_in[gidx_q]) begin
                    st_d = BUSY;
                end
            end
            BUSY: begin
                // A dropped req does not abort; the tenure ends after completion.
                if (wd_hit) begin
                    st_d    = RELEASE;
                    grant_d = '0;
                end else if (spi_done) begin
                    st_d   = GRANT;
                    done_d = grant_q;
                end
            end
            RELEASE: begin
                ptr_d = nxt_ptr;
                if (win_vld) begin
                    st_d    = GRANT;
                    grant_d = win_oh;
                    gidx_d  = win_idx;
                end else begin
                    st_d = IDLE;
                end
            end
            default: begin
                st_d    = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q    <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
        end else begin
            st_q    <= st_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign wd_hit = ((st_q == GRANT) || (st_q == BUSY)) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if ((st_d == GRANT) && (st_q != GRANT)) begin
            cnt_d = '0;
        end else if (spi_start || spi_done) begin
            cnt_d = '0;
        end else if ((st_q == GRANT) || (st_q == BUSY)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 1);
    assign wd_hit     = 1'b0;
`endif

    assign timeout  = wd_hit && !reset;
    assign grant    = grant_q;
    assign done_out = done_q;

    always_comb begin
        ss_out = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i] && !reset) ss_out[i] = spi_ss;
        end
    end

endmodule
